// File: rtl/magic_device_pkg.sv
`default_nettype none
// ============================================================================
// Module      : magic_device_pkg
// Description : Shared widths, FSM state encoding and response-entry layout
//               for the magic device burst requester.
// Revision    : 1.0 - initial release
// ============================================================================
package magic_device_pkg;

  localparam int SELECT_W = 12;
  localparam int DATA_W   = 64;
  localparam int LEN_W    = 8;

  // Two-state requester FSM, explicit 1-bit encoding
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_e;

  // One buffered response beat
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
    logic              err;
  } resp_entry_t;

endpackage
`default_nettype wire

// File: rtl/magic_resp_fifo.sv
`default_nettype none
// ============================================================================
// Module      : magic_resp_fifo
// Description : Synchronous response FIFO, generic in depth and entry type.
//               Head reads as all-zero while empty so downstream outputs are
//               clean without resetting the storage array.
// Revision    : 1.0 - initial release
// ============================================================================
module magic_resp_fifo #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = logic [7:0]
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   push,
  input  entry_t push_entry,
  input  logic   pop,
  output entry_t head,
  output logic   full,
  output logic   empty
);

  localparam int         AW      = (DEPTH < 2) ? 1 : $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit to tell full from empty
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  entry_t      mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer advance on guarded push/pop
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop && !empty) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage write; contents are don't-care until the pointers cover them
  always_ff @(posedge clock) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_entry;
  end

endmodule
`default_nettype wire

// File: rtl/magic_device_requester.sv
`default_nettype none
// ============================================================================
// Module      : magic_device_requester
// Description : Accepts a burst request, issues one device read per word
//               (one beat outstanding at a time), buffers the returned data
//               in a response FIFO and aborts a beat that stalls too long.
// Revision    : 1.0 - initial release
// ============================================================================
module magic_device_requester
  import magic_device_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [SELECT_W-1:0] req_select,
  input  logic [LEN_W-1:0]    req_len,
  output logic [SELECT_W-1:0] read_select,
  output logic                read_ready,
  input  logic                read_valid,
  input  logic [DATA_W-1:0]   read_data,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_data,
  output logic                resp_last,
  output logic                resp_err,
  output logic                busy
);

  localparam int                 CNT_W     = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]   CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [SELECT_W-1:0] SEL_ONE  = {{(SELECT_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0]   LEN_ONE   = {{(LEN_W-1){1'b0}}, 1'b1};

  state_e              state;
  logic [SELECT_W-1:0] addr;
  logic [LEN_W-1:0]    remaining;
  logic [CNT_W-1:0]    stall_cnt;

  logic        fifo_full;
  logic        fifo_empty;
  logic        beat_done;
  logic        timeout_hit;
  logic        push;
  resp_entry_t push_entry;
  resp_entry_t head;

  assign busy        = (state == ISSUE);
  assign req_ready   = (state == IDLE);
  assign read_ready  = busy && !fifo_full;
  // Select is parked at zero when idle so no stale address is presented
  assign read_select = busy ? addr : '0;

  // A beat completing on the timeout cycle wins over the abort
  assign beat_done   = read_ready && read_valid;
  assign timeout_hit = read_ready && !read_valid && (stall_cnt == TIMEOUT_C);
  assign push        = beat_done || timeout_hit;

  // Build the FIFO entry: device data for a real beat, zero/err for an abort
  always_comb begin
    push_entry = '0;
    if (beat_done) begin
      push_entry.data = read_data;
      push_entry.last = (remaining == '0);
      push_entry.err  = 1'b0;
    end else if (timeout_hit) begin
      push_entry.data = '0;
      push_entry.last = 1'b1;
      push_entry.err  = 1'b1;
    end
  end

  // Burst FSM, address/length tracking and stall counting
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      stall_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr      <= req_select;
            remaining <= req_len;
            stall_cnt <= '0;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (beat_done) begin
            addr      <= addr + SEL_ONE;
            remaining <= remaining - LEN_ONE;
            stall_cnt <= '0;
            if (remaining == '0) state <= IDLE;
          end else if (timeout_hit) begin
            stall_cnt <= '0;
            state     <= IDLE;
          end else if (read_ready) begin
            stall_cnt <= stall_cnt + CNT_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  magic_resp_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (resp_entry_t)
  ) u_resp_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (resp_valid && resp_ready),
    .head       (head),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  assign resp_valid = !fifo_empty;
  assign resp_data  = head.data;
  assign resp_last  = head.last;
  assign resp_err   = head.err;

endmodule
`default_nettype wire

// File: doc/magic_device_requester.md
MAGIC_DEVICE_REQUESTER -- requirements
Module: magic_device_requester

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, number of response buffer entries (power of two, minimum 2).
REQ-002 Parameter TIMEOUT, default 255, maximum cycles a device beat may stall before the block aborts it.
REQ-003 Port clock  input  1  single clock; all flops on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset; 0 = in reset.
REQ-005 Port req_valid  input  1  client burst request valid.
REQ-006 Port req_ready  output  1  block accepts a burst request.
REQ-007 Port req_select  input  12  first device word select.
REQ-008 Port req_len  input  8  burst length minus one (1..256 words).
REQ-009 Port read_select  output  12  word select driven to device.
REQ-010 Port read_ready  output  1  read request to device; held until beat completes.
REQ-011 Port read_valid  input  1  device data valid.
REQ-012 Port read_data  input  64  device data.
REQ-013 Port resp_valid  output  1  buffered response available.
REQ-014 Port resp_ready  input  1  client accepts response.
REQ-015 Port resp_data  output  64  response data.
REQ-016 Port resp_last  output  1  final beat of the burst.
REQ-017 Port resp_err  output  1  beat aborted by timeout; resp_data is 0.
REQ-018 Port busy  output  1  burst in progress (state != IDLE).

Function
REQ-019 The FSM SHALL have two states: IDLE and ISSUE.
REQ-020 In IDLE, req_ready SHALL be 1 and read_ready SHALL be 0; req_valid && req_ready SHALL latch addr=req_select and remaining=req_len, then enter ISSUE on the next cycle.
REQ-021 In ISSUE, req_ready SHALL be 0, read_select SHALL equal addr, and read_ready SHALL be 1 iff the FIFO is not full.
REQ-022 A beat SHALL complete on a cycle with read_valid && read_ready; read_valid with read_ready low SHALL be ignored.
REQ-023 A completed beat SHALL push {read_data, last=(remaining==0), err=0} into the FIFO in that same cycle.
REQ-024 After each completed beat, addr SHALL increment modulo 4096 (0xFFF wraps to 0x000) and remaining SHALL decrement; the last beat SHALL return the FSM to IDLE.
REQ-025 The stall counter SHALL increment each cycle read_ready && !read_valid, SHALL hold while read_ready is 0, and SHALL clear on any completed beat or on entering ISSUE.
REQ-026 When the stall counter reaches TIMEOUT, the block SHALL push {0, last=1, err=1}, abandon the remaining beats, clear the counter and return to IDLE.
REQ-027 If read_valid arrives in the same cycle the counter reaches TIMEOUT, the beat SHALL complete normally and no error SHALL be pushed.
REQ-028 resp_valid SHALL equal FIFO not-empty; resp_data, resp_last and resp_err SHALL show the FIFO head; resp_valid && resp_ready SHALL pop the head.
REQ-029 A push and a pop in the same cycle SHALL leave the occupancy unchanged; a push at full SHALL never occur, because read_ready is gated off at full.
REQ-030 Each completed beat SHALL be visible on resp_valid one cycle after completion (one-cycle FIFO latency, no bypass).
REQ-031 The block SHALL have at most one device beat outstanding.

Reset
REQ-032 While reset=0, the block SHALL be in state IDLE with FIFO empty, stall counter 0 and addr 0.
REQ-033 During and immediately after reset, outputs SHALL be: req_ready=1, read_ready=0, read_select=0, resp_valid=0, resp_data=0, resp_last=0, resp_err=0, busy=0.
REQ-034 Reset asserted mid-burst SHALL discard the burst and all buffered responses, with no response emitted afterwards.

Structure
REQ-035 Package magic_device_pkg SHALL hold SELECT_W=12, DATA_W=64, LEN_W=8, the state enum, and the response-entry struct {data, last, err}.
REQ-036 The FIFO SHALL be a sub-module magic_resp_fifo, parameterised by depth and entry type, with full/empty and push/pop ports.

Verification
REQ-037 Request select=0x010, len=3, device read_valid the cycle after read_ready, resp_ready=1 -> four beats with read_select 0x010..0x013, resp_last only on the 4th beat, busy clears after the last beat completes.
REQ-038 Request select=0xFFE, len=2 -> read_select sequence 0xFFE, 0xFFF, 0x000.
REQ-039 resp_ready=0, len=7, FIFO_DEPTH=4 -> read_ready drops after 4 pushes, stall counter holds; raising resp_ready resumes the burst with no lost or duplicated data.
REQ-040 Device never raises read_valid, TIMEOUT=255 -> after 255 stalled cycles one response with data=0, err=1, last=1; FSM in IDLE; req_ready=1.
REQ-041 reset driven low in the middle of an 8-beat burst -> outputs take their reset values asynchronously; no responses appear after release until a new request.
REQ-042 read_valid pulsed while in IDLE -> no FIFO push and resp_valid stays 0.
